i2c_init_sequencer: RTL
=======================

Name: i2c_init_sequencer

Overview:
- Upstream command source for the I2C write control FSM and its byte datapath.
- Walks a register-initialisation table (external synchronous ROM) and presents device address, sub-address high/low and data bytes for each entry.
- Pulses `write`, then waits for the controller's `ready` or `errory`.
- Recovers from NACK/timeout by resetting the controller and retrying; reports done/fail to the system.

Parameters:
- NUM_ENTRIES, 16, maximum table entries walked.
- IDX_W, 4, width of rom_addr; must satisfy 2^IDX_W >= NUM_ENTRIES.
- DEV_ADDR, 7'h1A, 7-bit slave address; driven as {DEV_ADDR,1'b0}.
- MAX_RETRY, 3, retries per entry after the first attempt.
- TIMEOUT, 4095, I2C_clk cycles allowed in WAIT before declaring an error.
- TO_W, 12, timeout counter width.
- GAP_CYCLES, 64, inter-transaction idle gap (see Optional Feature).

Ports:
- I2C_clk  in  1  clock, shared with the control FSM.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; sampled only in IDLE.
- rom_addr  out  IDX_W  table index.
- rom_data  in  24  {sub_addr[15:0], data[7:0]}; valid 1 cycle after rom_addr changes.
- dev_addr  out  8  {DEV_ADDR,0}.
- sub_addr_h  out  8  latched rom_data[23:16].
- sub_addr_l  out  8  latched rom_data[15:8].
- wr_data  out  8  latched rom_data[7:0].
- write  out  1  one-cycle request to the control FSM.
- ctrl_reset  out  1  active-high reset to the control FSM.
- ready  in  1  single-cycle completion pulse from the control FSM.
- errory  in  1  level; held while the control FSM is in Err.
- busy  out  1  high in every state except IDLE, DONE, FAIL.
- done  out  1  one-cycle pulse on successful completion.
- fail  out  1  level; set on retry exhaustion, cleared by next accepted start or reset.
- fail_index  out  IDX_W  index of the failing entry; valid while fail=1.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all byte outputs 0; rom_addr=0; retry=0; timer=0.
  - write=0, done=0, fail=0, busy=0, fail_index=0.
  - ctrl_reset=1 while reset is asserted and for 2 cycles after release.
- All outputs are registered. dev_addr is constant {DEV_ADDR,0}.
- States:
  - IDLE: on start=1 → FETCH; rom_addr=0, retry=0, fail cleared.
  - FETCH: one cycle of ROM latency → LATCH.
  - LATCH:
    - rom_data==24'hFFFFFF (end marker) → DONE.
    - Otherwise latch sub_addr_h, sub_addr_l, wr_data → ISSUE.
  - ISSUE: write=1 for exactly this one cycle; timer cleared → WAIT.
  - WAIT:
    - ready=1 → NEXT.
    - errory=1, or timer reaches TIMEOUT → RECOVER.
    - If ready and errory are both 1 in the same cycle, ready wins.
  - RECOVER: ctrl_reset=1 for 2 cycles, then:
    - retry<MAX_RETRY → retry+1, go to ISSUE; bytes unchanged, no refetch.
    - Otherwise → FAIL.
  - NEXT: retry=0. If rom_addr==NUM_ENTRIES-1 → DONE; else rom_addr+1 → FETCH (or GAP, see feature).
  - DONE: done=1 for one cycle → IDLE.
  - FAIL: fail=1, fail_index=rom_addr; go to IDLE in the same cycle (fail level persists).
- Byte outputs stay stable from LATCH until the next LATCH, including through retries.
- write never asserts outside ISSUE.
- start while busy is ignored.
- A ready pulse arriving outside WAIT is ignored.
- rom_addr increments without wrap; the NUM_ENTRIES bound terminates the walk first.
- Reset mid-transaction: immediate return to IDLE. Controller is held in reset via ctrl_reset; no done or fail is generated.

Optional Feature:
- Macro: I2C_SEQ_GAP_EN.
- Defined: NEXT → GAP state for GAP_CYCLES cycles (bus free time between STOP and START), then FETCH. busy stays 1 during GAP.
- Undefined: NEXT → FETCH directly; GAP state and its counter are not built.

Test Plan:
- Table of 3 entries then 24'hFFFFFF; bus model returns ready 40 cycles after each write → exactly 3 write pulses, bytes match entries, done pulses once, fail=0.
- NUM_ENTRIES=4, no end marker, all ACK → 4 writes, rom_addr stops at 3, done pulses once, no 5th fetch.
- Entry 1 NACKs once (errory held until ctrl_reset) → ctrl_reset high 2 cycles, second write carries identical bytes, sequence completes with done.
- Entry 2 NACKs every attempt, MAX_RETRY=3 → 4 writes on entry 2, fail=1, fail_index=2, no done; a new start clears fail.
- Controller silent (no ready, no errory), TIMEOUT=100 → RECOVER entered at 100 cycles in WAIT, repeated per retry, then fail=1.
- reset asserted in WAIT → all outputs return to reset values asynchronously; with I2C_SEQ_GAP_EN, measured gap between ready and next write ≥ GAP_CYCLES.

Source files
------------

// File: rtl/i2c_init_sequencer.sv
// Register-initialisation sequencer: walks an external ROM table and issues one I2C write per
// entry, retrying on NACK/timeout. Define I2C_SEQ_GAP_EN to insert a bus-free gap between writes.
module i2c_init_sequencer #(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned IDX_W       = 4,
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT     = 4095,
  parameter int unsigned TO_W        = 12,
  parameter int unsigned GAP_CYCLES  = 64
) (
  input  logic             I2C_clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [23:0]      rom_data,
  output logic [7:0]       dev_addr,
  output logic [7:0]       sub_addr_h,
  output logic [7:0]       sub_addr_l,
  output logic [7:0]       wr_data,
  output logic             write,
  output logic             ctrl_reset,
  input  logic             ready,
  input  logic             errory,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [IDX_W-1:0] fail_index
);

  localparam int unsigned RT_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [23:0]      END_MARK = 24'hFFFFFF;

  if ((2 ** IDX_W) < NUM_ENTRIES || GAP_CYCLES == 0 || TIMEOUT == 0) begin : g_param_err
    $error("i2c_init_sequencer: inconsistent parameters");
  end

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StLatch,
    StIssue,
    StWait,
    StRecover,
    StNext,
`ifdef I2C_SEQ_GAP_EN
    StGap,
`endif
    StDone,
    StFail
  } state_e;

  state_e          state_q;
  logic [1:0]      por_cnt_q;
  logic [RT_W-1:0] retry_q;
  logic [TO_W-1:0] timer_q;
  logic            rcv_q;

`ifdef I2C_SEQ_GAP_EN
  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  logic [GAP_W-1:0] gap_q;
`endif

  assign dev_addr = {DEV_ADDR, 1'b0};

  always_ff @(posedge I2C_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      por_cnt_q  <= 2'd2;
      retry_q    <= '0;
      timer_q    <= '0;
      rcv_q      <= 1'b0;
      rom_addr   <= '0;
      sub_addr_h <= 8'h00;
      sub_addr_l <= 8'h00;
      wr_data    <= 8'h00;
      write      <= 1'b0;
      ctrl_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_index <= '0;
`ifdef I2C_SEQ_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      // Pulses default low; controller stays in reset for two cycles after our own reset.
      write      <= 1'b0;
      done       <= 1'b0;
      ctrl_reset <= (por_cnt_q != 2'd0);
      if (por_cnt_q != 2'd0) begin
        por_cnt_q <= por_cnt_q - 2'd1;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StFetch;
            rom_addr <= '0;
            retry_q  <= '0;
            fail     <= 1'b0;
            busy     <= 1'b1;
          end
        end

        StFetch: state_q <= StLatch;

        StLatch: begin
          if (rom_data == END_MARK) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            sub_addr_h <= rom_data[23:16];
            sub_addr_l <= rom_data[15:8];
            wr_data    <= rom_data[7:0];
            write      <= 1'b1;
            state_q    <= StIssue;
          end
        end

        StIssue: begin
          timer_q <= '0;
          state_q <= StWait;
        end

        StWait: begin
          if (ready) begin
            state_q <= StNext;
          end else if (errory || timer_q == TO_LAST) begin
            state_q    <= StRecover;
            ctrl_reset <= 1'b1;
            rcv_q      <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        // Two cycles of controller reset; the retry re-enters ISSUE with the latched bytes.
        StRecover: begin
          if (!rcv_q) begin
            rcv_q      <= 1'b1;
            ctrl_reset <= 1'b1;
          end else if (retry_q < RT_MAX) begin
            retry_q <= retry_q + 1'b1;
            write   <= 1'b1;
            state_q <= StIssue;
          end else begin
            fail       <= 1'b1;
            fail_index <= rom_addr;
            busy       <= 1'b0;
            state_q    <= StFail;
          end
        end

        StNext: begin
          retry_q <= '0;
          if (rom_addr == LAST_IDX) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            rom_addr <= rom_addr + 1'b1;
`ifdef I2C_SEQ_GAP_EN
            gap_q    <= '0;
            state_q  <= StGap;
`else
            state_q  <= StFetch;
`endif
          end
        end

`ifdef I2C_SEQ_GAP_EN
        StGap: begin
          if (gap_q == GAP_LAST) begin
            state_q <= StFetch;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
`endif

        StDone: state_q <= StIdle;

        StFail: state_q <= StIdle;

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
